instr_mem_loadable: RTL and testbench

Parametrised, synchronous-read instruction memory for the ARM core's fetch stage.
- Program is streamed in through a load port instead of being hard-coded.
- Fetches use a req/ready/valid handshake with a one-entry output register, so the pipeline can stall the fetch stage.
- Addresses beyond the loaded program, and misaligned addresses, return a configurable NOP and raise a fault flag.

---
 rtl/instr_mem_loadable.sv | 164 ++++++++++++++++
 tb/tb_instr_mem_loadable.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory for the fetch stage: the program is streamed in through a load port,
// and fetches use a req/ready/valid handshake with a one-entry output register.
module instr_mem_loadable #(
  parameter int                 DATA_W    = 32,
  parameter int                 DEPTH     = 64,
  parameter int                 ADDR_W    = 32,
  parameter int                 BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0]  NOP_INSTR = 32'hE2800000,
  localparam int                LEN_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_full,
  output logic [LEN_W-1:0]  prog_len,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  input  logic              instr_stall,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              fault
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                full_q, full_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                fault_q, fault_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_en_s;
  logic                accept_s;
  logic                misalign_s;
  logic                hit_s;
  logic [ADDR_W-1:0]   idx_full_s;
  logic [IDX_W-1:0]    mem_idx_s;
  logic [DATA_W-1:0]   rd_data_s;

  assign fetch_ready = (state_q == S_RUN) && (!valid_q || !instr_stall);
  assign accept_s    = fetch_req && fetch_ready;

  // Address decode: the word index is only usable when it lies inside the loaded program.
  always_comb begin
    idx_full_s = (BYTE_ADDR != 0) ? (fetch_addr >> 2) : fetch_addr;
    misalign_s = (BYTE_ADDR != 0) && (fetch_addr[1:0] != 2'b00);
    hit_s      = (idx_full_s < ADDR_W'(len_q)) && !misalign_s;
    mem_idx_s  = idx_full_s[IDX_W-1:0];
    if (hit_s) begin
      rd_data_s = mem[mem_idx_s];
    end else begin
      rd_data_s = NOP_INSTR;
    end
  end

  // Next-state: mode FSM, load pointer and fetch output register.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    full_d  = full_q;
    valid_d = valid_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    fault_d = fault_q;
    wr_en_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d = S_LOAD;
          len_d   = {LEN_W{1'b0}};
          full_d  = 1'b0;
          valid_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // A word offered in the cycle load_en falls is still stored.
        if (load_valid && !full_q) begin
          wr_en_s = 1'b1;
          len_d   = len_q + LEN_W'(1);
          full_d  = ((len_q + LEN_W'(1)) == LEN_W'(DEPTH));
        end else begin
          wr_en_s = 1'b0;
        end
        if (!load_en) begin
          state_d = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (load_en) begin
          state_d = S_LOAD;
          len_d   = {LEN_W{1'b0}};
          full_d  = 1'b0;
          valid_d = 1'b0;
        end else if (accept_s) begin
          valid_d = 1'b1;
          instr_d = rd_data_s;
          addr_d  = fetch_addr;
          fault_d = !hit_s;
        end else if (valid_q && !instr_stall) begin
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= {LEN_W{1'b0}};
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      addr_q  <= {ADDR_W{1'b0}};
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      fault_q <= fault_d;
    end
  end

  // Program storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[len_q[IDX_W-1:0]] <= load_data;
    end
  end

  assign load_full   = full_q;
  assign prog_len    = len_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_addr  = addr_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: a word-addressed 64-deep instance and a byte-addressed 4-deep
// instance share stimulus and are compared every cycle against a program-queue reference model.
module tb_instr_mem_loadable;

  localparam logic [31:0] NOP = 32'hE2800000;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic        load_valid;
  logic [31:0] load_data;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        instr_stall;

  logic        full_a, full_b, ready_a, ready_b, valid_a, valid_b, fault_a, fault_b;
  logic [6:0]  len_a;
  logic [2:0]  len_b;
  logic [31:0] instr_a, instr_b, iaddr_a, iaddr_b;

  instr_mem_loadable dut_a (
    .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_full(full_a), .prog_len(len_a), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(ready_a), .instr_valid(valid_a), .instr_stall(instr_stall), .instr(instr_a),
    .instr_addr(iaddr_a), .fault(fault_a)
  );

  instr_mem_loadable #(.DEPTH(4), .BYTE_ADDR(1)) dut_b (
    .clk(clk), .rst(rst), .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_full(full_b), .prog_len(len_b), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(ready_b), .instr_valid(valid_b), .instr_stall(instr_stall), .instr(instr_b),
    .instr_addr(iaddr_b), .fault(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 idle, 1 loading, 2 running
  int          mst = 0;
  logic [31:0] prog_a[$];
  logic [31:0] prog_b[$];
  logic        mv = 1'b0;
  logic [31:0] mi_a, mi_b, ma;
  logic        mf_a, mf_b;
  logic        after_rst;
  logic [31:0] words[16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void exp_a(input logic [31:0] a, output logic [31:0] ins, output logic f);
    if (a < 32'(prog_a.size())) begin ins = prog_a[a]; f = 1'b0; end
    else begin ins = NOP; f = 1'b1; end
  endfunction

  function automatic void exp_b(input logic [31:0] a, output logic [31:0] ins, output logic f);
    if (a[1:0] != 2'b00 || (a >> 2) >= 32'(prog_b.size())) begin ins = NOP; f = 1'b1; end
    else begin ins = prog_b[a >> 2]; f = 1'b0; end
  endfunction

  // one clock: check ready before the edge, advance the model, check outputs after it
  task automatic step();
    logic c_rst, c_le, c_lv, c_st, acc, exp_rdy;
    logic [31:0] c_ld, c_fa;
    #1;
    exp_rdy = (mst == 2) && (!mv || !instr_stall);
    chk("ready_a", 64'(ready_a), 64'(exp_rdy));
    chk("ready_b", 64'(ready_b), 64'(exp_rdy));
    c_rst = rst; c_le = load_en; c_lv = load_valid; c_st = instr_stall;
    c_ld = load_data; c_fa = fetch_addr;
    acc = fetch_req && exp_rdy;
    @(posedge clk);
    #1;
    after_rst = c_rst;
    if (c_rst) begin
      mst = 0; prog_a.delete(); prog_b.delete();
      mv = 1'b0; mi_a = NOP; mi_b = NOP; ma = 32'd0; mf_a = 1'b0; mf_b = 1'b0;
    end else begin
      case (mst)
        0: if (c_le) begin mst = 1; prog_a.delete(); prog_b.delete(); mv = 1'b0; end
        1: begin
          if (c_lv) begin
            if (prog_a.size() < 64) prog_a.push_back(c_ld);
            if (prog_b.size() < 4)  prog_b.push_back(c_ld);
          end
          if (!c_le) mst = 2;
        end
        default: begin
          if (c_le) begin mst = 1; prog_a.delete(); prog_b.delete(); mv = 1'b0; end
          else if (acc) begin
            mv = 1'b1; ma = c_fa;
            exp_a(c_fa, mi_a, mf_a);
            exp_b(c_fa, mi_b, mf_b);
          end else if (mv && !c_st) mv = 1'b0;
        end
      endcase
    end
    chk("valid_a", 64'(valid_a), 64'(mv));
    chk("valid_b", 64'(valid_b), 64'(mv));
    chk("len_a", 64'(len_a), 64'(prog_a.size()));
    chk("len_b", 64'(len_b), 64'(prog_b.size()));
    chk("full_a", 64'(full_a), 64'(prog_a.size() == 64));
    chk("full_b", 64'(full_b), 64'(prog_b.size() == 4));
    if (mv || after_rst) begin
      chk("instr_a", 64'(instr_a), 64'(mi_a));
      chk("instr_b", 64'(instr_b), 64'(mi_b));
      chk("iaddr_a", 64'(iaddr_a), 64'(ma));
      chk("iaddr_b", 64'(iaddr_b), 64'(ma));
      chk("fault_a", 64'(fault_a), 64'(mf_a));
      chk("fault_b", 64'(fault_b), 64'(mf_b));
    end
  endtask

  task automatic do_load(input int n);
    load_en = 1'b1; load_valid = 1'b0; step();
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1; load_data = words[i]; step();
    end
    load_en = 1'b0; load_valid = 1'b0; step();
  endtask

  task automatic fetch1(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a; step();
    fetch_req = 1'b0; step();
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_data = 32'd0;
    fetch_req = 1'b0; fetch_addr = 32'd0; instr_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();

    // three-word program, single fetches in and out of range
    words[0] = 32'hE3A00014; words[1] = 32'hE3A01028; words[2] = 32'hE0902001;
    do_load(3);
    fetch1(32'd1);
    fetch1(32'd3);
    fetch1(32'd6);
    fetch1(32'd8);
    fetch1(32'd2);

    // back-to-back 0,1,2 with the second result stalled for two cycles
    fetch_req = 1'b1; fetch_addr = 32'd0; step();
    fetch_addr = 32'd1; step();
    fetch_addr = 32'd2; instr_stall = 1'b1; step();
    step();
    instr_stall = 1'b0; step();
    fetch_req = 1'b0; step();
    step();

    // over-long program into the 4-deep instance
    for (int i = 0; i < 6; i++) words[i] = 32'hA0000000 + 32'(i * 17);
    do_load(6);
    fetch1(32'd0);
    fetch1(32'd12);
    fetch1(32'd16);
    fetch1(32'd5);

    // reload while an output is held
    fetch_req = 1'b1; fetch_addr = 32'd0; step();
    fetch_req = 1'b0; load_en = 1'b1; step();
    words[0] = 32'hE3A0202A;
    do_load(1);
    fetch1(32'd0);
    fetch1(32'd1);

    // reset in the middle of a load
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    load_en = 1'b1; step();
    for (int i = 0; i < 2; i++) begin load_valid = 1'b1; load_data = words[i]; step(); end
    rst = 1'b1; step();
    rst = 1'b0; load_en = 1'b0; load_valid = 1'b0; step();
    fetch1(32'd0);

    // randomized programs and fetch traffic
    for (int r = 0; r < 4; r++) begin
      int n;
      n = int'($urandom_range(1, 7));
      for (int i = 0; i < n; i++) words[i] = $urandom;
      do_load(n);
      for (int c = 0; c < 40; c++) begin
        fetch_req   = 1'($urandom_range(0, 1));
        fetch_addr  = 32'($urandom_range(0, 31));
        instr_stall = ($urandom_range(0, 3) == 0);
        if (c == 20 && r == 2) load_valid = 1'b1; else load_valid = 1'b0;
        load_data = $urandom;
        step();
      end
      fetch_req = 1'b0; instr_stall = 1'b0; load_valid = 1'b0;
      step();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
